// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type of the slave response mux.
package ahblite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLV  = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } mux_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahblite_mux_wdog.sv
// Wait-state watchdog: counts stalled data-phase cycles of the selected slave and
// flags the cycle on which the transfer must be forcibly terminated.
module ahblite_mux_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] wcnt;

    // Saturates at TIMEOUT_CYCLES so a disabled or long-stalled watchdog never wraps.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wcnt <= '0;
        end else if (clr) begin
            wcnt <= '0;
        end else if (en && (wcnt != CNT_MAX)) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && en && !clr && (wcnt == CNT_LAST);

endmodule

// File: rtl/ahblite_slave_mux_n.sv
// AHB-Lite data-phase response mux for NUM_PORTS slaves with an integrated default
// slave, a wait-state watchdog and sticky error status.
module ahblite_slave_mux_n
    import ahblite_pkg::*;
#(
    parameter int NUM_PORTS      = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          HREADY,
    input  logic [1:0]                    HTRANS,
    input  logic [NUM_PORTS-1:0]          P_HSEL,
    input  logic [NUM_PORTS-1:0]          P_HREADYOUT,
    input  logic [NUM_PORTS-1:0]          P_HRESP,
    input  logic [NUM_PORTS*DATA_W-1:0]   P_HRDATA,
    input  logic                          STATUS_CLR,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [DATA_W-1:0]             HRDATA,
    output logic                          DECODE_ERR,
    output logic                          TIMEOUT_ERR,
    output logic [$clog2(NUM_PORTS)-1:0]  TIMEOUT_PORT,
    output logic [1:0]                    dbg_state
);

    localparam int IW = $clog2(NUM_PORTS);

    // Handshake: an address phase is accepted on every edge with HREADY=1 (active when
    // HTRANS[1]=1); its data phase completes on the first later edge with HREADYOUT=1.

    function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_PORTS; i++) n += int'(v[i]);
        return (n == 1);
    endfunction

    function automatic logic [IW-1:0] encode(input logic [NUM_PORTS-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) if (v[i]) idx = IW'(i);
        return idx;
    endfunction

    mux_state_e    state_q;
    logic [IW-1:0] sel_q;
    logic          ready_sel;
    logic          wdog_expire;
    logic          unused_htrans0;

    assign ready_sel      = P_HREADYOUT[sel_q];
    assign unused_htrans0 = HTRANS[0];
    assign dbg_state      = state_q;

    ahblite_mux_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .clr    (HREADY),
        .en     ((state_q == ST_SLV) && !ready_sel),
        .expire (wdog_expire)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            DECODE_ERR   <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
            TIMEOUT_PORT <= '0;
        end else begin
            // Clear first so a same-cycle set below wins.
            if (STATUS_CLR) begin
                DECODE_ERR  <= 1'b0;
                TIMEOUT_ERR <= 1'b0;
            end
            if (state_q == ST_ERR1) begin
                state_q <= ST_ERR2;
            end else if (HREADY) begin
                if (!HTRANS[1]) begin
                    state_q <= ST_IDLE;
                end else if (is_onehot(P_HSEL)) begin
                    state_q <= ST_SLV;
                    sel_q   <= encode(P_HSEL);
                end else begin
                    state_q    <= ST_ERR1;
                    DECODE_ERR <= 1'b1;
                end
            end else if ((state_q == ST_SLV) && wdog_expire) begin
                state_q      <= ST_ERR1;
                TIMEOUT_ERR  <= 1'b1;
                TIMEOUT_PORT <= sel_q;
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        case (state_q)
            ST_SLV: begin
                HREADYOUT = ready_sel;
                HRESP     = P_HRESP[sel_q];
                HRDATA    = P_HRDATA[int'(sel_q)*DATA_W +: DATA_W];
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP = HRESP_ERROR;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ahblite_slave_mux_n.md
# ahblite_slave_mux_n

Parametrised AHB-Lite data-phase response multiplexer for the SoC bus matrix, returning one of NUM_PORTS slave responses to the master. Successor to the fixed five-port mux: adds an integrated default slave (two-cycle ERROR for unmapped or multiply-selected addresses), a per-transfer wait-state watchdog that terminates hung slaves with ERROR, and sticky error status for the system controller.

## Interface
- NUM_PORTS, 5, number of slave ports (2..16)
- DATA_W, 32, HRDATA width
- TIMEOUT_CYCLES, 256, maximum consecutive slave wait states before forced ERROR; 0 disables the watchdog
- HCLK  in  1  bus clock
- HRESETn  in  1  reset, asynchronous, active-low
- HREADY  in  1  bus-level ready (address phase sampled when 1)
- HTRANS  in  2  master transfer type; bit 1 = NONSEQ/SEQ
- P_HSEL  in  NUM_PORTS  decoder selects, bit i = port i
- P_HREADYOUT  in  NUM_PORTS  slave ready outputs
- P_HRESP  in  NUM_PORTS  slave responses
- P_HRDATA  in  NUM_PORTS*DATA_W  slave read data, port i at [i*DATA_W +: DATA_W]
- STATUS_CLR  in  1  one-cycle pulse clearing sticky flags
- HREADYOUT  out  1  muxed ready to master
- HRESP  out  1  muxed response to master
- HRDATA  out  DATA_W  muxed read data
- DECODE_ERR  out  1  sticky: zero or >1 HSEL on an active transfer
- TIMEOUT_ERR  out  1  sticky: watchdog fired
- TIMEOUT_PORT  out  $clog2(NUM_PORTS)  port index of most recent timeout

## Operation
- States: IDLE, SLV, ERR1, ERR2.
- Address sample when HREADY=1 (any state): active = HTRANS[1]. Not active -> IDLE. Active with exactly one P_HSEL bit -> SLV, register port index sel_q. Active with zero or >1 bits -> ERR1, set DECODE_ERR.
- IDLE: HREADYOUT=1, HRESP=0, HRDATA=0 (zero-wait OKAY).
- SLV: outputs = P_HREADYOUT[sel_q], P_HRESP[sel_q], P_HRDATA slice sel_q. Slave ERROR responses pass through unmodified.
- ERR1: HREADYOUT=0, HRESP=1, HRDATA=0; unconditionally -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1, HRDATA=0; address sampled (HREADY=1) and next state chosen as above.
- Watchdog: counter wcnt cleared on every address sample; increments each SLV cycle with selected P_HREADYOUT=0. If P_HREADYOUT[sel_q]=0 while wcnt==TIMEOUT_CYCLES-1 -> ERR1, set TIMEOUT_ERR, TIMEOUT_PORT<=sel_q. Slave responses thereafter ignored for that transfer.
- Sticky flags: set has priority over STATUS_CLR in the same cycle.
- In ERR1, HREADY=0, so no sampling; master may change HTRANS freely.

## Timing
- Reset values: state IDLE, sel_q=0, wcnt=0, HREADYOUT=1, HRESP=0, HRDATA=0, DECODE_ERR=0, TIMEOUT_ERR=0, TIMEOUT_PORT=0.
- Async reset mid-transfer: immediate return to reset values; no response completed.
- Outputs combinational from registered state/sel_q and slave inputs; no added latency in SLV.
- Decode error: exactly 2 data-phase cycles (ERR1, ERR2).
- Timeout: master sees TIMEOUT_CYCLES low-ready cycles from slave, then ERR1, ERR2 = TIMEOUT_CYCLES+2 cycles total.
- Slave asserting ready in the same cycle wcnt reaches TIMEOUT_CYCLES-1: slave wins, no timeout.
- Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

## Structure
- Package ahblite_pkg: state enum (IDLE/SLV/ERR1/ERR2), HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), HRESP OKAY/ERROR constants.
- Sub-module ahblite_mux_wdog: watchdog counter with clear/enable/expire, parameter TIMEOUT_CYCLES.
- One-hot check and index encode as functions in the top module.

## Test plan
- NUM_PORTS=5: NONSEQ, P_HSEL=5'b00100, port 2 returns 0xDEADBEEF zero-wait -> HRDATA=0xDEADBEEF, HRESP=0 next cycle.
- NONSEQ, P_HSEL=0 -> HREADYOUT 0 then 1 with HRESP=1 both cycles, DECODE_ERR=1; STATUS_CLR -> 0.
- NONSEQ, P_HSEL=5'b00011 -> two-cycle ERROR, DECODE_ERR=1, no slave data forwarded.
- TIMEOUT_CYCLES=4, port 3 holds ready low -> 4 wait cycles, ERR1, ERR2; TIMEOUT_ERR=1, TIMEOUT_PORT=3.
- TIMEOUT_CYCLES=4, port 1 ready on 4th wait cycle -> OKAY completion, TIMEOUT_ERR stays 0; HTRANS=IDLE -> zero-wait OKAY, HRDATA=0.
- HRESETn pulsed during ERR1 -> HREADYOUT=1, HRESP=0, flags 0 immediately.
